result_seg_driver: RTL

- Downstream display stage for the calculator datapath.
- Accepts an 8-bit product with a one-cycle load pulse and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Time-multiplexes eight digits over the two segment groups: decimal result on the right group, high nibble in binary on the left group.
- Replaces ad-hoc scan logic in the calculator top level.

---
 rtl/result_seg_driver.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/result_seg_driver.sv
// result_seg_driver: converts an 8-bit result to BCD one bit per cycle (shift-add-3)
// and time-multiplexes eight 7-segment digits across two segment groups.
module result_seg_driver #(
    parameter int SCAN_DIV  = 10000,
    parameter int CONV_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CONV_BITS-1:0] value,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           anode,
    output logic [7:0]           Seg1,
    output logic [7:0]           Seg2
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(CONV_BITS);
    localparam int BCD_W  = 12;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] ITER_LAST = IDX_W'(CONV_BITS - 1);

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ZERO  = 8'hFC;

    // Reset image: binary nibble 0000, hundreds/tens blank, units "0".
    localparam logic [7:0] RESET_PAT [8] = '{SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO,
                                             SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'hFC;
            4'd1:    p = 8'h60;
            4'd2:    p = 8'hDA;
            4'd3:    p = 8'hF2;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'hB6;
            4'd6:    p = 8'hBE;
            4'd7:    p = 8'hE0;
            4'd8:    p = 8'hFE;
            4'd9:    p = 8'hF6;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Conversion state
    state_t               state_q, state_d;
    logic [CONV_BITS-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_adj;
    logic [IDX_W-1:0]     iter_q, iter_d;
    logic [3:0]           nib_q, nib_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 commit;

    // Committed display image, one segment pattern per digit
    logic [7:0] disp_q [8];
    logic [7:0] disp_d [8];
    logic [7:0] commit_pat [8];
    logic [3:0] hund, tens, units;

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [7:0]       anode_q, anode_d;
    logic [7:0]       seg1_q, seg1_d;
    logic [7:0]       seg2_q, seg2_d;
    logic             advance;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                               : bcd_q[gi*4 +: 4];
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        nib_d   = nib_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    shift_d = value;
                    nib_d   = value[CONV_BITS-1 -: 4];
                    bcd_d   = '0;
                    iter_d  = '0;
                end
            end
            S_SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = commit;
    end

    assign hund  = bcd_q[11:8];
    assign tens  = bcd_q[7:4];
    assign units = bcd_q[3:0];

    // Digits 0-3 show the high nibble MSB first; the decimal field is zero-suppressed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            commit_pat[i] = seg_of({3'b000, nib_q[3-i]});
        end
        commit_pat[4] = SEG_BLANK;
        commit_pat[5] = (hund == 4'd0) ? SEG_BLANK : seg_of(hund);
        commit_pat[6] = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_of(tens);
        commit_pat[7] = seg_of(units);
    end

    always_comb begin
        disp_d = disp_q;
        if (commit) begin
            disp_d = commit_pat;
        end
    end

    // Outputs only move at slot boundaries, so a commit mid-slot appears next slot.
    always_comb begin
        advance = (cnt_q == SCAN_LAST);
        cnt_d   = advance ? '0 : cnt_q + 1'b1;
        digit_d = advance ? digit_q + 3'd1 : digit_q;
        anode_d = anode_q;
        seg1_d  = seg1_q;
        seg2_d  = seg2_q;
        if (advance) begin
            anode_d = 8'd1 << digit_d;
            seg1_d  = digit_d[2] ? SEG_BLANK : disp_q[digit_d];
            seg2_d  = digit_d[2] ? disp_q[digit_d] : SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            nib_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= RESET_PAT;
            cnt_q   <= '0;
            digit_q <= 3'd0;
            anode_q <= 8'b0000_0001;
            seg1_q  <= SEG_BLANK;
            seg2_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            nib_q   <= nib_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            anode_q <= anode_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign anode = anode_q;
    assign Seg1  = seg1_q;
    assign Seg2  = seg2_q;

endmodule
